// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC client scheduler:
// op codes, arbiter state, default latency and clog2.
package cordic_pkg;

   localparam logic [1:0] OP_P2R   = 2'd0;
   localparam logic [1:0] OP_R2P   = 2'd1;
   localparam logic [1:0] OP_SLAVE = 2'd3;

   typedef enum logic {
      ST_RR,
      ST_LOCK
   } arb_st_t;

   function automatic int lat_default(input int w);
      return w + 3;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// Round-robin arbiter with pointer and single-cycle
// lock used to keep slave-mode request pairs together.
module cordic_rr_arb
   import cordic_pkg::*;
#(
   parameter int nch = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [nch-1:0]         i_valid,
   input  logic [nch-1:0]         i_pair,
   output logic [nch-1:0]         o_grant,
   output logic [clog2(nch)-1:0]  o_idx,
   output logic                   o_vld
);

   localparam int CW = clog2(nch);

   arb_st_t       r_state;
   arb_st_t       w_state_nx;
   logic [CW-1:0] r_ptr;
   logic [CW-1:0] w_ptr_nx;
   logic [CW-1:0] r_lock;
   logic [CW-1:0] w_lock_nx;
   logic [CW-1:0] w_cand;

   // State, pointer and locked channel registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_RR;
         r_ptr   <= CW'(nch - 1);
         r_lock  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_ptr   <= w_ptr_nx;
         r_lock  <= w_lock_nx;
      end
   end

   // Grant selection and next-state logic; nothing granted in reset
   always_comb begin
      o_grant    = '0;
      o_idx      = '0;
      o_vld      = 1'b0;
      w_cand     = '0;
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_lock_nx  = r_lock;
      if (rst_n) begin
         unique case (r_state)
            ST_RR: begin
               for (int i = 1; i <= nch; i++) begin
                  w_cand = CW'((int'(r_ptr) + i) % nch);
                  if (!o_vld && i_valid[w_cand]) begin
                     o_vld = 1'b1;
                     o_idx = w_cand;
                  end
               end
               if (o_vld) begin
                  w_ptr_nx = o_idx;
                  if (i_pair[o_idx]) begin
                     w_state_nx = ST_LOCK;
                     w_lock_nx  = o_idx;
                  end
               end
            end
            ST_LOCK: begin
               w_state_nx = ST_RR;
               if (i_valid[r_lock]) begin
                  o_vld    = 1'b1;
                  o_idx    = r_lock;
                  w_ptr_nx = r_lock;
               end
            end
         endcase
         if (o_vld) o_grant[o_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cordic_sched.sv
// Multi-channel front end for a pipelined CORDIC:
// arbitrates requests, issues them, and tags results.
module cordic_sched
   import cordic_pkg::*;
#(
   parameter int         width   = 19,
   parameter int         nch     = 4,
   parameter int         latency = lat_default(width),
   parameter logic [1:0] def_op  = OP_P2R
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [nch-1:0]           req_valid,
   output logic [nch-1:0]           req_ready,
   input  logic [nch-1:0]           req_pair,
   input  logic [2*nch-1:0]         req_op,
   input  logic [width*nch-1:0]     req_x,
   input  logic [width*nch-1:0]     req_y,
   input  logic [(width+1)*nch-1:0] req_phase,
   output logic [1:0]               c_op,
   output logic [width-1:0]         c_x,
   output logic [width-1:0]         c_y,
   output logic [width:0]           c_phase,
   input  logic [width-1:0]         c_xout,
   input  logic [width-1:0]         c_yout,
   input  logic [width:0]           c_phaseout,
   output logic                     res_valid,
   output logic [clog2(nch)-1:0]    res_chan,
   output logic [width-1:0]         res_x,
   output logic [width-1:0]         res_y,
   output logic [width:0]           res_phase
);

   localparam int CW = clog2(nch);
   localparam int PW = width + 1;
   // CORDIC input register plus its pipeline, counted from c_*
   localparam int TD = latency + 2;

   logic [nch-1:0]   w_grant;
   logic [CW-1:0]    w_idx;
   logic             w_vld;

   logic [1:0]       r_c_op;
   logic [width-1:0] r_c_x;
   logic [width-1:0] r_c_y;
   logic [PW-1:0]    r_c_ph;

   logic [TD-1:0]    r_tv;
   logic [CW-1:0]    r_tc [TD];

   logic             r_res_v;
   logic [CW-1:0]    r_res_c;
   logic [width-1:0] r_res_x;
   logic [width-1:0] r_res_y;
   logic [PW-1:0]    r_res_ph;

   cordic_rr_arb #(
      .nch (nch)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (req_valid),
      .i_pair  (req_pair),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_vld   (w_vld)
   );

   assign req_ready = w_grant;

   // Issue register: granted channel's operands, idle values otherwise
   always_ff @(posedge clk) begin
      if (!rst_n || !w_vld) begin
         r_c_op <= def_op;
         r_c_x  <= '0;
         r_c_y  <= '0;
         r_c_ph <= '0;
      end else begin
         r_c_op <= req_op[2*int'(w_idx) +: 2];
         r_c_x  <= req_x[width*int'(w_idx) +: width];
         r_c_y  <= req_y[width*int'(w_idx) +: width];
         r_c_ph <= req_phase[PW*int'(w_idx) +: PW];
      end
   end

   assign c_op    = r_c_op;
   assign c_x     = r_c_x;
   assign c_y     = r_c_y;
   assign c_phase = r_c_ph;

   // Tag delay line tracking {valid, chan} alongside the CORDIC
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tv <= '0;
         for (int i = 0; i < TD; i++) r_tc[i] <= '0;
      end else begin
         r_tv    <= {r_tv[TD-2:0], w_vld};
         r_tc[0] <= w_idx;
         for (int i = 1; i < TD; i++) r_tc[i] <= r_tc[i-1];
      end
   end

   // Result register: capture CORDIC output when its tag is valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_res_v  <= 1'b0;
         r_res_c  <= '0;
         r_res_x  <= '0;
         r_res_y  <= '0;
         r_res_ph <= '0;
      end else begin
         r_res_v <= r_tv[TD-1];
         if (r_tv[TD-1]) begin
            r_res_c  <= r_tc[TD-1];
            r_res_x  <= c_xout;
            r_res_y  <= c_yout;
            r_res_ph <= c_phaseout;
         end
      end
   end

   assign res_valid = r_res_v;
   assign res_chan  = r_res_c;
   assign res_x     = r_res_x;
   assign res_y     = r_res_y;
   assign res_phase = r_res_ph;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: stand-in CORDIC delay model,
// result scoreboard and per-feature directed tasks.
module tb_cordic_sched;

   localparam int         W   = 19;
   localparam int         N   = 4;
   localparam int         LAT = 22;
   localparam int         PW  = W + 1;
   localparam logic [1:0] DEF = 2'd0;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   req_pair = '0;
   logic [2*N-1:0] req_op = '0;
   logic [W*N-1:0] req_x = '0;
   logic [W*N-1:0] req_y = '0;
   logic [PW*N-1:0] req_phase = '0;
   logic [1:0]     c_op;
   logic [W-1:0]   c_x, c_y, c_xout, c_yout;
   logic [PW-1:0]  c_phase, c_phaseout;
   logic           res_valid;
   logic [1:0]     res_chan;
   logic [W-1:0]   res_x, res_y;
   logic [PW-1:0]  res_phase;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [1:0]    chan;
      logic [W-1:0]  x;
      logic [W-1:0]  y;
      logic [PW-1:0] ph;
      int            cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t me;
   exp_t pe;

   function automatic logic [W-1:0] fx(input logic [W-1:0] v);
      return v ^ 19'h2A5A5;
   endfunction
   function automatic logic [W-1:0] fy(input logic [W-1:0] v);
      return v + 19'd3;
   endfunction
   function automatic logic [PW-1:0] fp(input logic [PW-1:0] v,
                                        input logic [1:0] op);
      return v + {18'd0, op};
   endfunction

   cordic_sched #(
      .width   (W),
      .nch     (N),
      .latency (LAT),
      .def_op  (DEF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pair   (req_pair),
      .req_op     (req_op),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_phase  (req_phase),
      .c_op       (c_op),
      .c_x        (c_x),
      .c_y        (c_y),
      .c_phase    (c_phase),
      .c_xout     (c_xout),
      .c_yout     (c_yout),
      .c_phaseout (c_phaseout),
      .res_valid  (res_valid),
      .res_chan   (res_chan),
      .res_x      (res_x),
      .res_y      (res_y),
      .res_phase  (res_phase)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in CORDIC: input register plus LAT stages, no reset
   logic [1:0]    mo [LAT+1];
   logic [W-1:0]  mx [LAT+1];
   logic [W-1:0]  my [LAT+1];
   logic [PW-1:0] mp [LAT+1];

   always @(posedge clk) begin
      mo[0] <= c_op;
      mx[0] <= c_x;
      my[0] <= c_y;
      mp[0] <= c_phase;
      for (int i = 1; i <= LAT; i++) begin
         mo[i] <= mo[i-1];
         mx[i] <= mx[i-1];
         my[i] <= my[i-1];
         mp[i] <= mp[i-1];
      end
   end

   assign c_xout     = fx(mx[LAT]);
   assign c_yout     = fy(my[LAT]);
   assign c_phaseout = fp(mp[LAT], mo[LAT]);

   // Scoreboard: push on transfer, pop and compare on res_valid
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
      end else begin
         if (res_valid) begin
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: res_valid chan=%0d, none expected",
                        res_chan);
            end else begin
               me = sbq.pop_front();
               if (res_chan !== me.chan || res_x !== me.x ||
                   res_y !== me.y || res_phase !== me.ph ||
                   cyc !== me.cyc) begin
                  bad++;
                  $display("FAIL sb_result: got ch=%0d x=%h y=%h p=%h t=%0d want ch=%0d x=%h y=%h p=%h t=%0d",
                           res_chan, res_x, res_y, res_phase, cyc,
                           me.chan, me.x, me.y, me.ph, me.cyc);
               end
            end
         end
         for (int k = 0; k < N; k++) begin
            if (req_valid[k] && req_ready[k]) begin
               pe.chan = 2'(k);
               pe.x    = fx(req_x[W*k +: W]);
               pe.y    = fy(req_y[W*k +: W]);
               pe.ph   = fp(req_phase[PW*k +: PW], req_op[2*k +: 2]);
               pe.cyc  = cyc + LAT + 3;
               sbq.push_back(pe);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      req_valid = '0;
      req_pair  = '0;
   endtask

   task automatic setc(input int k, input logic [1:0] op,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [PW-1:0] ph);
      req_op[2*k +: 2]     = op;
      req_x[W*k +: W]      = x;
      req_y[W*k +: W]      = y;
      req_phase[PW*k +: PW] = ph;
   endtask

   task automatic do_reset();
      clr();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 3*LAT && sbq.size() != 0; i++)
         @(negedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d results outstanding, want 0",
                  nm, sbq.size());
         sbq.delete();
      end
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '1;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL rst_ready: got %b want 0000", req_ready);
      end
      step();
      step();
      rst_n = 1'b1;
      clr();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if (res_valid !== 1'b0 || c_op !== DEF || c_x !== '0 ||
             c_y !== '0 || c_phase !== '0 || res_chan !== '0 ||
             res_x !== '0 || res_y !== '0 || res_phase !== '0) begin
            bad++;
            $display("FAIL idle_%0d: rv=%b op=%0d x=%h y=%h p=%h ch=%0d rx=%h, want all 0",
                     i, res_valid, c_op, c_x, c_y, c_phase, res_chan, res_x);
         end
      end
      step();
   endtask

   task automatic test_single();
      setc(2, 2'd1, 19'd1000, 19'd0, 20'd0);
      req_valid = 4'b0100;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      step();
      clr();
      wait_drain("single");
   endtask

   task automatic test_all();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < N; k++)
            setc(k, 2'(k), 19'(i*4 + k), 19'(500 + i),
                 20'(i*16 + k));
         req_valid = '1;
         @(negedge clk);
         total++;
         if (req_ready !== 4'(1 << (i % 4))) begin
            bad++;
            $display("FAIL all_grant_%0d: got %b want %b",
                     i, req_ready, 4'(1 << (i % 4)));
         end
         step();
      end
      clr();
      wait_drain("all");
   endtask

   task automatic test_pair();
      do_reset();
      setc(0, 2'd2, 19'd11, 19'd12, 20'd13);
      req_valid = 4'b0001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL pair_g0: got %b want 0001", req_ready);
      end
      step();
      setc(1, 2'd1, 19'd21, 19'd22, 20'd23);
      req_pair  = 4'b0010;
      req_valid = 4'b0011;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010 || c_op !== 2'd2) begin
         bad++;
         $display("FAIL pair_g1: got rdy=%b op=%0d want 0010 op=2",
                  req_ready, c_op);
      end
      step();
      setc(1, 2'd3, 19'd31, 19'd32, 20'd33);
      req_pair = 4'b0000;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010 || c_op !== 2'd1) begin
         bad++;
         $display("FAIL pair_g2: got rdy=%b op=%0d want 0010 op=1",
                  req_ready, c_op);
      end
      step();
      req_valid = 4'b0001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001 || c_op !== 2'd3) begin
         bad++;
         $display("FAIL pair_g3: got rdy=%b op=%0d want 0001 op=3",
                  req_ready, c_op);
      end
      step();
      clr();
      @(negedge clk);
      total++;
      if (c_op !== 2'd2) begin
         bad++;
         $display("FAIL pair_op4: got op=%0d want 2", c_op);
      end
      wait_drain("pair");
   endtask

   task automatic test_lock_drop();
      do_reset();
      setc(1, 2'd1, 19'd41, 19'd42, 20'd43);
      setc(2, 2'd3, 19'd51, 19'd52, 20'd53);
      setc(3, 2'd2, 19'd61, 19'd62, 20'd63);
      req_pair  = 4'b0010;
      req_valid = 4'b0110;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL drop_g0: got %b want 0010", req_ready);
      end
      step();
      req_pair  = 4'b0000;
      req_valid = 4'b1100;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL drop_idle: got %b want 0000", req_ready);
      end
      step();
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100 || c_op !== DEF || c_x !== '0) begin
         bad++;
         $display("FAIL drop_g1: got rdy=%b op=%0d x=%h want 0100 op=0 x=0",
                  req_ready, c_op, c_x);
      end
      step();
      @(negedge clk);
      total++;
      if (req_ready !== 4'b1000 || c_op !== 2'd3) begin
         bad++;
         $display("FAIL drop_g2: got rdy=%b op=%0d want 1000 op=3",
                  req_ready, c_op);
      end
      step();
      clr();
      wait_drain("drop");
   endtask

   task automatic test_reset_flight();
      int seen;
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < N; k++)
            setc(k, 2'd1, 19'(700 + i), 19'(k), 20'(i));
         req_valid = '1;
         step();
      end
      clr();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL flush: %0d res_valid after reset, want 0", seen);
      end
      step();
      setc(2, 2'd0, 19'd1234, 19'd4321, 20'd99);
      req_valid = 4'b0100;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100) begin
         bad++;
         $display("FAIL flush_ready: got %b want 0100", req_ready);
      end
      step();
      clr();
      wait_drain("flush");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_all();
      test_pair();
      test_lock_drop();
      test_reset_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
